// File: rtl/plru_replacement_unit_pkg.sv
// rtl/plru_replacement_unit_pkg.sv - shared types for the tree pseudo-LRU replacement engine
package lc3b_types;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } plru_state_t;

    function automatic int plru_tree_width(input int ways);
        return ways - 1;
    endfunction

endpackage

// File: rtl/plru_tree_next.sv
// rtl/plru_tree_next.sv - combinational PLRU tree update and victim selection
module plru_tree_next #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         tree,
    input  logic [$clog2(WAYS)-1:0] way,
    output logic [WAYS-2:0]         tree_next,
    output logic [$clog2(WAYS)-1:0] victim
);

    localparam int LV = $clog2(WAYS);

    // Node k at depth d lies on the path whose way prefix (top d bits) equals k.
    always_comb begin
        tree_next = tree;
        for (int d = 0; d < LV; d++) begin
            for (int k = 0; k < (1 << d); k++) begin
                if ((way >> (LV - d)) == LV'(k)) begin
                    tree_next[(1 << d) - 1 + k] = way[LV - 1 - d];
                end
            end
        end
    end

    // Victim bits are produced MSB first; bits already chosen select the next node.
    always_comb begin
        victim = '0;
        for (int d = 0; d < LV; d++) begin
            for (int k = 0; k < (1 << d); k++) begin
                if ((victim >> (LV - d)) == LV'(k)) begin
                    victim[LV - 1 - d] = ~tree[(1 << d) - 1 + k];
                end
            end
        end
    end

endmodule

// File: rtl/plru_replacement_unit.sv
// rtl/plru_replacement_unit.sv - per-set tree pseudo-LRU store with victim lookup and flush
module plru_replacement_unit
    import lc3b_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    access_valid,
    input  logic [$clog2(SETS)-1:0] access_set,
    input  logic [$clog2(WAYS)-1:0] access_way,
    input  logic                    victim_req,
    input  logic [$clog2(SETS)-1:0] victim_set,
    output logic                    victim_valid,
    output logic [$clog2(WAYS)-1:0] victim_way,
    input  logic                    flush_req,
    output logic                    busy,
    output logic                    flush_done
);

    localparam int TW = plru_tree_width(WAYS);
    localparam int WW = $clog2(WAYS);
    localparam int SW = $clog2(SETS);

    logic [TW-1:0] trees [SETS];

    plru_state_t   state, state_nxt;
    logic [SW-1:0] cnt, cnt_nxt;
    logic          done_nxt;

    logic [TW-1:0] upd_tree;
    logic [TW-1:0] byp_tree;
    logic [WW-1:0] sel_victim;
    logic [WW-1:0] unused_victim_a;
    logic [TW-1:0] unused_tree_v;

    plru_tree_next #(.WAYS(WAYS)) u_access (
        .tree      (trees[access_set]),
        .way       (access_way),
        .tree_next (upd_tree),
        .victim    (unused_victim_a)
    );

    // A same-set access this cycle must be visible to the victim lookup.
    assign byp_tree = (access_valid && access_set == victim_set) ? upd_tree : trees[victim_set];

    plru_tree_next #(.WAYS(WAYS)) u_victim (
        .tree      (byp_tree),
        .way       (access_way),
        .tree_next (unused_tree_v),
        .victim    (sel_victim)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == SW'(SETS - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            flush_done   <= 1'b0;
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            flush_done   <= done_nxt;
            victim_valid <= victim_req && (state == IDLE);
            if (victim_req && state == IDLE) begin
                victim_way <= sel_victim;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                trees[s] <= '0;
            end
        end else if (state == FLUSH) begin
            trees[cnt] <= '0;
        end else if (access_valid) begin
            trees[access_set] <= upd_tree;
        end
    end

endmodule

// File: tb/tb_plru_replacement_unit.sv
// tb/tb_plru_replacement_unit.sv - scoreboard bench for plru_replacement_unit
module tb_plru_replacement_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       access_valid;
    logic [2:0] access_set;
    logic [1:0] access_way;
    logic       victim_req;
    logic [2:0] victim_set;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       flush_req;
    logic       busy;
    logic       flush_done;

    int checks = 0;
    int fails  = 0;
    logic [1:0] exp_q [$];

    plru_replacement_unit #(.WAYS(4), .SETS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .access_valid (access_valid),
        .access_set   (access_set),
        .access_way   (access_way),
        .victim_req   (victim_req),
        .victim_set   (victim_set),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .flush_req    (flush_req),
        .busy         (busy),
        .flush_done   (flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (victim_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL victim_unexpected: got victim_valid=1 way=%0d expected no response", victim_way);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (victim_way !== e) begin
                    fails++;
                    $display("FAIL victim_way: got %0d expected %0d", victim_way, e);
                end
            end
        end
    end

    // Drives one cycle of stimulus; expect_resp pushes the scoreboard entry.
    task automatic cycle(input logic av, input logic [2:0] aset, input logic [1:0] away,
                         input logic vr, input logic [2:0] vset,
                         input logic expect_resp, input logic [1:0] exp_way);
        access_valid = av;
        access_set   = aset;
        access_way   = away;
        victim_req   = vr;
        victim_set   = vset;
        if (vr && expect_resp) exp_q.push_back(exp_way);
        @(posedge clk);
        #1;
        access_valid = 1'b0;
        victim_req   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        access_valid = 1'b0;
        access_set   = '0;
        access_way   = '0;
        victim_req   = 1'b0;
        victim_set   = '0;
        flush_req    = 1'b0;
        idle_cycles(3);
        check("reset_busy", busy, 0);
        check("reset_flush_done", flush_done, 0);
        check("reset_victim_valid", victim_valid, 0);
        check("reset_victim_way", victim_way, 0);
        rst_n = 1'b1;
        idle_cycles(1);

        cycle(0, 0, 0, 1, 5, 1, 2'd3);
        cycle(1, 3, 2, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 1, 2'd1);

        for (int w = 0; w < 4; w++) cycle(1, 0, 2'(w), 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1, 2'd0);
        cycle(0, 0, 0, 1, 1, 1, 2'd3);

        cycle(1, 4, 3, 1, 4, 1, 2'd1);
        cycle(1, 6, 3, 1, 7, 1, 2'd3);
        idle_cycles(2);

        for (int s = 0; s < 8; s++) cycle(1, 3'(s), 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 7, 1, 2'd1);
        idle_cycles(1);

        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("flush_busy_c%0d", i + 1), busy, 1);
            check($sformatf("flush_nodone_c%0d", i + 1), flush_done, 0);
            flush_req = 1'b1;
            cycle(1, 3'(7 - i), 3, 1, 3'(i), 0, 0);
            flush_req = 1'b0;
        end
        check("flush_end_busy", busy, 0);
        check("flush_done_pulse", flush_done, 1);
        idle_cycles(1);
        check("flush_done_clear", flush_done, 0);
        check("flush_idle_busy", busy, 0);
        for (int s = 0; s < 8; s++) cycle(0, 0, 0, 1, 3'(s), 1, 2'd3);
        idle_cycles(2);

        for (int s = 0; s < 8; s++) cycle(1, 3'(s), 3, 0, 0, 0, 0);
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        idle_cycles(2);
        check("mid_flush_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_done", flush_done, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("post_reset_nodone_%0d", i), flush_done, 0);
            idle_cycles(1);
        end
        for (int s = 0; s < 8; s++) cycle(0, 0, 0, 1, 3'(s), 1, 2'd3);
        idle_cycles(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
